// File: rtl/decode_issue.sv
// decode_issue: single-slot decode/issue stage with a register busy scoreboard.
// Decodes the offered instruction, checks RAW/WAW hazards against in-flight
// writes and issues into one registered ex_* slot with a valid/ready handshake.
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   instr_valid/instr/pc       fetch offer; instr_ready accepts it (combinational)
//   readReg1/readReg2          register file read addresses
//   wb_valid/wb_reg            writeback completion, clears the busy bit
//   flush                      discards the occupied ex slot
//   ex_valid/ex_ready          downstream handshake
//   ex_pc..ex_illegal          registered decoded fields of the issued instruction
module decode_issue #(
  parameter int unsigned DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 instr_valid,
  input  logic [31:0]          instr,
  input  logic [DATAWIDTH-1:0] pc,
  output logic                 instr_ready,
  output logic [4:0]           readReg1,
  output logic [4:0]           readReg2,
  input  logic                 wb_valid,
  input  logic [4:0]           wb_reg,
  input  logic                 flush,
  output logic                 ex_valid,
  input  logic                 ex_ready,
  output logic [DATAWIDTH-1:0] ex_pc,
  output logic [DATAWIDTH-1:0] ex_imm,
  output logic [4:0]           ex_rd,
  output logic [6:0]           ex_opcode,
  output logic [2:0]           ex_funct3,
  output logic                 ex_funct7b5,
  output logic                 ex_regwrite,
  output logic                 ex_illegal
);

  localparam int unsigned NREG = 32;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  logic [6:0]           w_opcode;
  logic [4:0]           w_rs1;
  logic [4:0]           w_rs2;
  logic [4:0]           w_rd;
  logic                 w_rs1_used;
  logic                 w_rs2_used;
  logic                 w_wr_type;
  logic                 w_regwrite;
  logic                 w_illegal;
  logic [31:0]          w_imm32;
  logic [DATAWIDTH-1:0] w_imm;
  logic [NREG-1:0]      w_wb_clr;
  logic [NREG-1:0]      w_busy_eff;
  logic [NREG-1:0]      w_busy_nxt;
  logic                 w_hazard;
  logic                 w_accept;
  logic                 w_hold;

  logic [NREG-1:0]      r_busy;
  logic                 r_ex_valid;
  logic [DATAWIDTH-1:0] r_ex_pc;
  logic [DATAWIDTH-1:0] r_ex_imm;
  logic [4:0]           r_ex_rd;
  logic [6:0]           r_ex_opcode;
  logic [2:0]           r_ex_funct3;
  logic                 r_ex_funct7b5;
  logic                 r_ex_regwrite;
  logic                 r_ex_illegal;
  logic [4:0]           r_rs1;
  logic [4:0]           r_rs2;

  assign w_opcode = instr[6:0];
  assign w_rd     = instr[11:7];
  assign w_rs1    = instr[19:15];
  assign w_rs2    = instr[24:20];

  // Opcode classification, source usage and immediate formation.
  always_comb begin
    w_rs1_used = 1'b0;
    w_rs2_used = 1'b0;
    w_wr_type  = 1'b0;
    w_illegal  = 1'b0;
    w_imm32    = 32'd0;
    case (w_opcode)
      OP_R: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_wr_type  = 1'b1;
      end
      OP_IMM, OP_LOAD, OP_JALR: begin
        w_rs1_used = 1'b1;
        w_wr_type  = 1'b1;
        w_imm32    = {{20{instr[31]}}, instr[31:20]};
      end
      OP_STORE: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_imm32    = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        w_rs1_used = 1'b1;
        w_rs2_used = 1'b1;
        w_imm32    = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        w_wr_type = 1'b1;
        w_imm32   = {instr[31:12], 12'd0};
      end
      OP_JAL: begin
        w_wr_type = 1'b1;
        w_imm32   = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      end
      default: w_illegal = 1'b1;
    endcase
  end

  assign w_regwrite = w_wr_type && (w_rd != 5'd0);
  assign w_imm      = DATAWIDTH'($signed(w_imm32));

  // A same-cycle writeback already counts as done; the register file bypasses it.
  assign w_wb_clr   = (wb_valid && (wb_reg != 5'd0)) ? (NREG'(1) << wb_reg) : '0;
  assign w_busy_eff = r_busy & ~w_wb_clr;

  assign w_hazard = (w_rs1_used && w_busy_eff[w_rs1]) ||
                    (w_rs2_used && w_busy_eff[w_rs2]) ||
                    (w_regwrite && w_busy_eff[w_rd]);

  assign instr_ready = !w_hazard && !flush && (!r_ex_valid || ex_ready);
  assign w_accept    = instr_valid && instr_ready;

  // Scoreboard next state: clears first, so a same-cycle set wins.
  always_comb begin
    w_busy_nxt = w_busy_eff;
    if (flush && r_ex_valid && r_ex_regwrite) begin
      w_busy_nxt[r_ex_rd] = 1'b0;
    end
    if (w_accept && w_regwrite) begin
      w_busy_nxt[w_rd] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  // Read addresses stay on the occupied slot while it is stalled so the
  // registered read data stays aligned with the held ex_* fields.
  assign w_hold   = r_ex_valid && !ex_ready;
  assign readReg1 = (instr_valid && !w_hold) ? w_rs1 : r_rs1;
  assign readReg2 = (instr_valid && !w_hold) ? w_rs2 : r_rs2;

  // Issue slot and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy        <= '0;
      r_ex_valid    <= 1'b0;
      r_ex_pc       <= '0;
      r_ex_imm      <= '0;
      r_ex_rd       <= 5'd0;
      r_ex_opcode   <= 7'd0;
      r_ex_funct3   <= 3'd0;
      r_ex_funct7b5 <= 1'b0;
      r_ex_regwrite <= 1'b0;
      r_ex_illegal  <= 1'b0;
      r_rs1         <= 5'd0;
      r_rs2         <= 5'd0;
    end else begin
      r_busy <= w_busy_nxt;
      if (flush) begin
        r_ex_valid <= 1'b0;
      end else if (w_accept) begin
        r_ex_valid    <= 1'b1;
        r_ex_pc       <= pc;
        r_ex_imm      <= w_imm;
        r_ex_rd       <= w_rd;
        r_ex_opcode   <= w_opcode;
        r_ex_funct3   <= instr[14:12];
        r_ex_funct7b5 <= instr[30];
        r_ex_regwrite <= w_regwrite;
        r_ex_illegal  <= w_illegal;
        r_rs1         <= w_rs1;
        r_rs2         <= w_rs2;
      end else if (ex_ready) begin
        r_ex_valid <= 1'b0;
      end
    end
  end

  assign ex_valid    = r_ex_valid;
  assign ex_pc       = r_ex_pc;
  assign ex_imm      = r_ex_imm;
  assign ex_rd       = r_ex_rd;
  assign ex_opcode   = r_ex_opcode;
  assign ex_funct3   = r_ex_funct3;
  assign ex_funct7b5 = r_ex_funct7b5;
  assign ex_regwrite = r_ex_regwrite;
  assign ex_illegal  = r_ex_illegal;

endmodule

// File: tb/tb_decode_issue.sv
// tb_decode_issue: directed scenarios plus randomized traffic checked against
// a behavioural decode/scoreboard model.
module tb_decode_issue;

  logic        clk;
  logic        rst_n;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instr_ready;
  logic [4:0]  readReg1;
  logic [4:0]  readReg2;
  logic        wb_valid;
  logic [4:0]  wb_reg;
  logic        flush;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_pc;
  logic [31:0] ex_imm;
  logic [4:0]  ex_rd;
  logic [6:0]  ex_opcode;
  logic [2:0]  ex_funct3;
  logic        ex_funct7b5;
  logic        ex_regwrite;
  logic        ex_illegal;

  int checks;
  int failures;

  decode_issue #(.DATAWIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid(instr_valid), .instr(instr), .pc(pc), .instr_ready(instr_ready),
    .readReg1(readReg1), .readReg2(readReg2),
    .wb_valid(wb_valid), .wb_reg(wb_reg), .flush(flush),
    .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_pc(ex_pc), .ex_imm(ex_imm), .ex_rd(ex_rd), .ex_opcode(ex_opcode),
    .ex_funct3(ex_funct3), .ex_funct7b5(ex_funct7b5),
    .ex_regwrite(ex_regwrite), .ex_illegal(ex_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    instr_valid = 1'b0;
    instr       = 32'd0;
    pc          = 32'd0;
    wb_valid    = 1'b0;
    wb_reg      = 5'd0;
    flush       = 1'b0;
  endtask

  // Instruction class from the opcode table.
  function automatic byte ref_type(input logic [6:0] op);
    case (op)
      7'b0110011:                         return "R";
      7'b0010011, 7'b0000011, 7'b1100111: return "I";
      7'b0100011:                         return "S";
      7'b1100011:                         return "B";
      7'b0110111, 7'b0010111:             return "U";
      7'b1101111:                         return "J";
      default:                            return "X";
    endcase
  endfunction

  // Immediate value computed arithmetically from the bit-field placement.
  function automatic logic [31:0] ref_imm(input logic [31:0] ins, input byte t);
    int v;
    logic signed [11:0] i12;
    logic signed [11:0] s12;
    v = 0;
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    case (t)
      "I": v = int'(i12);
      "S": v = int'(s12);
      "B": v = (ins[31] ? -4096 : 0) + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
      "U": v = int'(ins[31:12]) * 4096;
      "J": v = (ins[31] ? -1048576 : 0) + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048 + int'(ins[30:21]) * 2;
      default: v = 0;
    endcase
    return 32'(v);
  endfunction

  task automatic test_reset();
    idle();
    ex_ready = 1'b1;
    rst_n = 1'b0;
    tick();
    tick();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL reset_ex_valid got=%b exp=0", ex_valid); end
    checks++; if ({ex_pc, ex_imm, ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_regwrite, ex_illegal} !== '0) begin
      failures++; $display("FAIL reset_ex_fields got pc=%h imm=%h rd=%0d exp all zero", ex_pc, ex_imm, ex_rd); end
    checks++; if (dut.r_busy !== 32'd0) begin failures++; $display("FAIL reset_busy got=%h exp=0", dut.r_busy); end
    checks++; if ({readReg1, readReg2} !== 10'd0) begin failures++; $display("FAIL reset_readreg got=%0d/%0d exp=0/0", readReg1, readReg2); end
  endtask

  // First accept right after reset release: addi x5,x0,1.
  task automatic test_addi();
    rst_n = 1'b1;
    instr_valid = 1'b1; instr = 32'h00100293; pc = 32'h100; ex_ready = 1'b1;
    #1;
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL addi_ready got=%b exp=1", instr_ready); end
    checks++; if (readReg1 !== 5'd0 || readReg2 !== 5'd1) begin failures++; $display("FAIL addi_readreg got=%0d/%0d exp=0/1", readReg1, readReg2); end
    tick();
    idle();
    checks++; if (ex_valid !== 1'b1) begin failures++; $display("FAIL addi_ex_valid got=%b exp=1", ex_valid); end
    checks++; if (ex_rd !== 5'd5 || ex_imm !== 32'd1 || ex_pc !== 32'h100) begin
      failures++; $display("FAIL addi_fields got rd=%0d imm=%h pc=%h exp rd=5 imm=1 pc=100", ex_rd, ex_imm, ex_pc); end
    checks++; if (ex_regwrite !== 1'b1 || ex_illegal !== 1'b0) begin failures++; $display("FAIL addi_flags got rw=%b ill=%b exp 1/0", ex_regwrite, ex_illegal); end
    checks++; if (dut.r_busy !== 32'h20) begin failures++; $display("FAIL addi_busy got=%h exp=20", dut.r_busy); end
  endtask

  // add x6,x5,x5 waits for x5 writeback, accepted in the writeback cycle.
  task automatic test_raw();
    instr_valid = 1'b1; instr = 32'h00528333; pc = 32'h104;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL raw_stall_%0d got=%b exp=0", i, instr_ready); end
      tick();
    end
    wb_valid = 1'b1; wb_reg = 5'd5;
    #1;
    checks++; if (instr_ready !== 1'b1) begin failures++; $display("FAIL raw_wb_ready got=%b exp=1", instr_ready); end
    tick();
    idle();
    checks++; if (ex_valid !== 1'b1 || ex_rd !== 5'd6) begin failures++; $display("FAIL raw_issue got v=%b rd=%0d exp 1/6", ex_valid, ex_rd); end
    checks++; if (dut.r_busy !== 32'h40) begin failures++; $display("FAIL raw_busy got=%h exp=40", dut.r_busy); end
    wb_valid = 1'b1; wb_reg = 5'd6;
    tick();
    idle();
    checks++; if (dut.r_busy !== 32'd0 || ex_valid !== 1'b0) begin failures++; $display("FAIL raw_drain got busy=%h v=%b exp 0/0", dut.r_busy, ex_valid); end
  endtask

  // beq with imm -4 leaves the scoreboard untouched.
  task automatic test_branch();
    instr_valid = 1'b1; instr = 32'h00100493; pc = 32'h1FC;
    tick();
    instr = 32'hFE000EE3; pc = 32'h200;
    tick();
    idle();
    checks++; if (ex_imm !== 32'hFFFFFFFC) begin failures++; $display("FAIL beq_imm got=%h exp=fffffffc", ex_imm); end
    checks++; if (ex_regwrite !== 1'b0 || ex_opcode !== 7'h63 || ex_pc !== 32'h200) begin
      failures++; $display("FAIL beq_fields got rw=%b op=%h pc=%h exp 0/63/200", ex_regwrite, ex_opcode, ex_pc); end
    checks++; if (dut.r_busy !== 32'h200) begin failures++; $display("FAIL beq_busy got=%h exp=200", dut.r_busy); end
    wb_valid = 1'b1; wb_reg = 5'd9;
    tick();
    idle();
  endtask

  // Downstream stall holds the slot and read addresses for 3 cycles.
  task automatic test_stall();
    instr_valid = 1'b1; instr = 32'h00508193; pc = 32'h300; ex_ready = 1'b0;
    tick();
    instr = 32'h00000013; pc = 32'h304;
    for (int i = 0; i < 3; i++) begin
      checks++; if (ex_valid !== 1'b1 || ex_imm !== 32'd5 || ex_rd !== 5'd3 || ex_pc !== 32'h300) begin
        failures++; $display("FAIL stall_fields_%0d got v=%b imm=%h rd=%0d pc=%h exp 1/5/3/300", i, ex_valid, ex_imm, ex_rd, ex_pc); end
      checks++; if (readReg1 !== 5'd1 || readReg2 !== 5'd5) begin
        failures++; $display("FAIL stall_readreg_%0d got=%0d/%0d exp=1/5", i, readReg1, readReg2); end
      checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL stall_ready_%0d got=%b exp=0", i, instr_ready); end
      tick();
    end
    idle();
    ex_ready = 1'b1;
    tick();
    checks++; if (ex_valid !== 1'b0) begin failures++; $display("FAIL stall_drain got=%b exp=0", ex_valid); end
    wb_valid = 1'b1; wb_reg = 5'd3;
    tick();
    idle();
  endtask

  // Flush of an occupied lui x7 slot releases x7.
  task automatic test_flush();
    instr_valid = 1'b1; instr = 32'h123453B7; pc = 32'h400; ex_ready = 1'b0;
    tick();
    idle();
    checks++; if (ex_valid !== 1'b1 || ex_imm !== 32'h12345000 || dut.r_busy !== 32'h80) begin
      failures++; $display("FAIL lui_issue got v=%b imm=%h busy=%h exp 1/12345000/80", ex_valid, ex_imm, dut.r_busy); end
    flush = 1'b1; instr_valid = 1'b1; instr = 32'h00100093;
    #1;
    checks++; if (instr_ready !== 1'b0) begin failures++; $display("FAIL flush_ready got=%b exp=0", instr_ready); end
    tick();
    idle();
    checks++; if (ex_valid !== 1'b0 || dut.r_busy !== 32'd0) begin
      failures++; $display("FAIL flush_result got v=%b busy=%h exp 0/0", ex_valid, dut.r_busy); end
  endtask

  // Reset asserted between edges during a stall acts immediately.
  task automatic test_reset_midstall();
    instr_valid = 1'b1; instr = 32'h00100293; pc = 32'h500; ex_ready = 1'b0;
    tick();
    idle();
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    checks++; if (ex_valid !== 1'b0 || dut.r_busy !== 32'd0) begin
      failures++; $display("FAIL async_reset got v=%b busy=%h exp 0/0", ex_valid, dut.r_busy); end
    checks++; if (ex_rd !== 5'd0 || ex_imm !== 32'd0) begin failures++; $display("FAIL async_reset_fields got rd=%0d imm=%h exp 0/0", ex_rd, ex_imm); end
    tick();
    rst_n = 1'b1;
    ex_ready = 1'b1;
  endtask

  task automatic test_random();
    logic [6:0]  ops [9];
    logic [31:0] m_busy;
    logic [31:0] eff;
    logic        m_valid;
    logic [31:0] m_pc, m_imm;
    logic [4:0]  m_rd, m_rs1, m_rs2;
    logic [6:0]  m_op;
    logic [2:0]  m_f3;
    logic        m_f7, m_rw, m_ill;
    logic [31:0] ins;
    logic [4:0]  e_r1, e_r2;
    byte         t;
    logic        rs1u, rs2u, rw, haz, e_ready, acc;
    int          idx;
    ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
            7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111};
    m_busy = '0; m_valid = 1'b0;
    m_pc = '0; m_imm = '0; m_rd = '0; m_rs1 = '0; m_rs2 = '0;
    m_op = '0; m_f3 = '0; m_f7 = 1'b0; m_rw = 1'b0; m_ill = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      idx = int'($urandom_range(9));
      ins = $urandom;
      ins[6:0]   = (idx == 9) ? 7'($urandom_range(127)) : ops[idx];
      ins[11:7]  = 5'($urandom_range(7));
      ins[19:15] = 5'($urandom_range(7));
      ins[24:20] = 5'($urandom_range(7));
      instr_valid = ($urandom_range(3) != 0);
      instr    = ins;
      pc       = $urandom;
      ex_ready = ($urandom_range(2) != 0);
      flush    = ($urandom_range(15) == 0);
      wb_valid = ($urandom_range(2) == 0);
      wb_reg   = 5'($urandom_range(7));
      #1;
      t    = ref_type(ins[6:0]);
      rs1u = (t == "R" || t == "I" || t == "S" || t == "B");
      rs2u = (t == "R" || t == "S" || t == "B");
      rw   = (t == "R" || t == "I" || t == "U" || t == "J") && (ins[11:7] != 5'd0);
      eff  = m_busy;
      if (wb_valid && wb_reg != 5'd0) eff[wb_reg] = 1'b0;
      haz = (rs1u && eff[ins[19:15]]) || (rs2u && eff[ins[24:20]]) || (rw && eff[ins[11:7]]);
      e_ready = !haz && !flush && (!m_valid || ex_ready);
      if (m_valid && !ex_ready) begin e_r1 = m_rs1; e_r2 = m_rs2; end
      else if (instr_valid)      begin e_r1 = ins[19:15]; e_r2 = ins[24:20]; end
      else                       begin e_r1 = m_rs1; e_r2 = m_rs2; end
      checks++; if (instr_ready !== e_ready) begin failures++; $display("FAIL rnd_ready cyc=%0d got=%b exp=%b", cyc, instr_ready, e_ready); end
      checks++; if (readReg1 !== e_r1 || readReg2 !== e_r2) begin
        failures++; $display("FAIL rnd_readreg cyc=%0d got=%0d/%0d exp=%0d/%0d", cyc, readReg1, readReg2, e_r1, e_r2); end
      acc = instr_valid && e_ready;
      if (flush && m_valid && m_rw) eff[m_rd] = 1'b0;
      if (acc && rw) eff[ins[11:7]] = 1'b1;
      m_busy = eff;
      if (flush) m_valid = 1'b0;
      else if (acc) begin
        m_valid = 1'b1; m_pc = pc; m_imm = ref_imm(ins, t); m_rd = ins[11:7];
        m_op = ins[6:0]; m_f3 = ins[14:12]; m_f7 = ins[30]; m_rw = rw; m_ill = (t == "X");
        m_rs1 = ins[19:15]; m_rs2 = ins[24:20];
      end else if (ex_ready) m_valid = 1'b0;
      tick();
      checks++; if (ex_valid !== m_valid) begin failures++; $display("FAIL rnd_ex_valid cyc=%0d got=%b exp=%b", cyc, ex_valid, m_valid); end
      checks++; if (dut.r_busy !== m_busy) begin failures++; $display("FAIL rnd_busy cyc=%0d got=%h exp=%h", cyc, dut.r_busy, m_busy); end
      if (m_valid) begin
        checks++;
        if (ex_pc !== m_pc || ex_imm !== m_imm || ex_rd !== m_rd || ex_opcode !== m_op ||
            ex_funct3 !== m_f3 || ex_funct7b5 !== m_f7 || ex_regwrite !== m_rw || ex_illegal !== m_ill) begin
          failures++;
          $display("FAIL rnd_fields cyc=%0d got pc=%h imm=%h rd=%0d op=%h f3=%0d f7=%b rw=%b ill=%b exp pc=%h imm=%h rd=%0d op=%h f3=%0d f7=%b rw=%b ill=%b",
                   cyc, ex_pc, ex_imm, ex_rd, ex_opcode, ex_funct3, ex_funct7b5, ex_regwrite, ex_illegal,
                   m_pc, m_imm, m_rd, m_op, m_f3, m_f7, m_rw, m_ill);
        end
      end
    end
    idle();
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_addi();
    test_raw();
    test_branch();
    test_stall();
    test_flush();
    test_reset_midstall();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/decode_issue.md
DECODE_ISSUE -- requirements
Module: decode_issue

Parameters
REQ-001 The block SHALL have parameter DATAWIDTH, default 32, giving the width of pc and immediate paths.

Interface
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on posedge.
REQ-003 The block SHALL have port rst_n, input, 1, an asynchronous active-low reset.
REQ-004 The block SHALL have port instr_valid, input, 1, meaning fetch offers an instruction.
REQ-005 The block SHALL have port instr, input, 32, the offered instruction word.
REQ-006 The block SHALL have port pc, input, DATAWIDTH, the address of instr.
REQ-007 The block SHALL have port instr_ready, output, 1, meaning the instruction is accepted this cycle.
REQ-008 The block SHALL have ports readReg1 and readReg2, output, 5 each, the register file read addresses.
REQ-009 The block SHALL have ports wb_valid, input, 1, and wb_reg, input, 5, a writeback completing to wb_reg.
REQ-010 The block SHALL have port flush, input, 1, which discards the occupied output slot.
REQ-011 The block SHALL have ports ex_valid, output, 1, and ex_ready, input, 1, the downstream handshake.
REQ-012 The block SHALL have ex_pc (DATAWIDTH), ex_imm (DATAWIDTH), ex_rd (5), ex_opcode (7), ex_funct3 (3), ex_funct7b5 (1), ex_regwrite (1) and ex_illegal (1), all outputs.

Function
REQ-013 Decode types: R 0110011; I 0010011, 0000011, 1100111; S 0100011; B 1100011; U 0110111, 0010111; J 1101111.
REQ-014 Immediates SHALL be sign-extended to DATAWIDTH: I inst[31:20]; S {inst[31:25],inst[11:7]}; B {inst[31],inst[7],inst[30:25],inst[11:8],0}; U {inst[31:12],12'b0}; J {inst[31],inst[19:12],inst[20],inst[30:21],0}; R gives 0.
REQ-015 rs1 is used by R/I/S/B; rs2 is used by R/S/B; rd is written by R/I/U/J only when rd != 0.
REQ-016 Any other opcode SHALL set ex_illegal=1 and ex_regwrite=0, use no sources, and still issue.
REQ-017 A 32-bit busy scoreboard SHALL be kept; bit 0 SHALL always read 0.
REQ-018 hazard = (rs1 used and busy[rs1]) or (rs2 used and busy[rs2]) or (regwrite and busy[rd]).
REQ-019 A busy bit cleared by wb_valid in the same cycle SHALL count as not busy for hazard; this is safe because the register file bypasses same-cycle writes.
REQ-020 instr_ready = !hazard and !flush and (!ex_valid or ex_ready).
REQ-021 On accept (instr_valid and instr_ready), the ex_* outputs SHALL load on the next edge and ex_valid=1; this is one-cycle latency, aligned with the registered register file read data.
REQ-022 On accept with regwrite, busy[rd] SHALL be set; if wb_valid clears the same bit in the same cycle, set wins.
REQ-023 On wb_valid with wb_reg != 0 and no same-bit set, busy[wb_reg] SHALL clear; wb_reg=0 is ignored.
REQ-024 On a cycle with instr_valid, readReg1/2 SHALL be instr[19:15]/instr[24:20]; otherwise they SHALL hold the occupied slot's rs1/rs2 values.
REQ-025 When ex_valid=1 and ex_ready=0, all ex_* outputs and readReg1/2 SHALL hold stable.
REQ-026 When ex_valid=1, ex_ready=1 and there is no new accept, ex_valid SHALL drop to 0 on the next edge.
REQ-027 On flush, ex_valid SHALL clear next edge; if the flushed slot has ex_regwrite, busy[ex_rd] SHALL clear; no accept occurs that cycle.
REQ-028 instr_ready SHALL be combinational; ex_* outputs SHALL be registered.

Reset
REQ-029 While rst_n=0, ex_valid SHALL be 0, all ex_* fields 0, busy all 0, and held readReg1/2 0, asynchronously.
REQ-030 The first accept SHALL be possible on the first clock edge after rst_n rises.

Verification
REQ-031 Scenario: issue addi x5,x0,1 (0x00100293) -> next cycle ex_valid=1, ex_rd=5, ex_imm=1, ex_regwrite=1, busy[5]=1.
REQ-032 Scenario: then add x6,x5,x5 offered -> instr_ready=0 until wb_valid with wb_reg=5; it is accepted in that wb cycle.
REQ-033 Scenario: beq with imm -4 (0xFE000EE3) -> ex_imm=0xFFFFFFFC, ex_regwrite=0, busy unchanged.
REQ-034 Scenario: ex_ready=0 for 3 cycles with ex_valid=1 -> ex_* and readReg1/2 are constant and instr_ready=0.
REQ-035 Scenario: flush on an occupied lui x7 slot -> ex_valid=0 next cycle, busy[7]=0.
REQ-036 Scenario: rst_n low mid-stall -> ex_valid=0 and busy=0 immediately, without a clock edge.
